// File: rtl/stream_pkg.sv
`default_nettype none
// ============================================================================
// Module      : stream_pkg
// Description : Shared definitions for the stream width converters: byte
//               width, FSM state encoding and the byte-count clamp helper.
// Revision    : 1.0 - initial release
// ============================================================================
package stream_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    // Counts past the last byte of a word (possible when NB is not a power
    // of two) saturate to the top byte.
    function automatic int cnt_clamp(input int cnt, input int nb);
        return (cnt >= nb) ? (nb - 1) : cnt;
    endfunction

endpackage
`default_nettype wire

// File: rtl/stream_unpacker_if.sv
`default_nettype none
// ============================================================================
// Module      : stream_unpacker_if
// Description : Word-in / byte-out handshake bundle of stream_unpacker.
//               master = surrounding logic, slave = the unpacker.
// Revision    : 1.0 - initial release
// ============================================================================
interface stream_unpacker_if
    import stream_pkg::*;
#(
    parameter int NB = 4
);
    localparam int CW = (NB > 2) ? $clog2(NB) : 1;

    logic                 i_rdy;
    logic                 i_en;
    logic [BYTE_W*NB-1:0] i_data;
    logic [CW-1:0]        i_cnt;
    logic                 i_last;
    logic                 o_rdy;
    logic                 o_en;
    logic [BYTE_W-1:0]    o_data;
    logic                 o_last;

    modport master (
        input  i_rdy, o_en, o_data, o_last,
        output i_en, i_data, i_cnt, i_last, o_rdy
    );

    modport slave (
        output i_rdy, o_en, o_data, o_last,
        input  i_en, i_data, i_cnt, i_last, o_rdy
    );

endinterface
`default_nettype wire

// File: rtl/stream_unpacker.sv
`default_nettype none
// ============================================================================
// Module      : stream_unpacker
// Description : Drains NB-byte words (count + last flag) and emits them one
//               byte per handshake. Build option STREAM_UNPACKER_MSB_FIRST_EN
//               selects most-significant-byte-first ordering.
// Revision    : 1.0 - initial release
// ============================================================================
module stream_unpacker
    import stream_pkg::*;
#(
    parameter int NB = 4
)(
    input  wire logic         clk,
    input  wire logic         rstn,
    stream_unpacker_if.slave  bus
);

    localparam int CW     = (NB > 2) ? $clog2(NB) : 1;
    localparam int WORD_W = BYTE_W * NB;

    state_t              state_q, state_d;
    logic [WORD_W-1:0]   word_q, word_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [CW-1:0]       idx_q, idx_d;
    logic                last_q, last_d;
    logic [BYTE_W-1:0]   data_q, data_d;
    logic                olast_q, olast_d;

    logic                out_fire;
    logic                in_fire;
    logic                last_byte;
    logic                rdy;
    logic [CW-1:0]       in_cnt;
    logic [CW-1:0]       sel_idx;
    logic [CW-1:0]       sel_pos;
    logic [WORD_W-1:0]   sel_word;

    assign last_byte = (idx_q == cnt_q);
    assign out_fire  = (state_q == ST_BUSY) & bus.o_rdy;
    assign rdy       = (state_q == ST_IDLE) | (out_fire & last_byte);
    assign in_fire   = bus.i_en & rdy;
    assign in_cnt    = CW'(cnt_clamp(int'(bus.i_cnt), NB));

    always_comb begin
        state_d  = state_q;
        word_d   = word_q;
        cnt_d    = cnt_q;
        last_d   = last_q;
        idx_d    = idx_q;
        data_d   = data_q;
        olast_d  = olast_q;
        sel_word = word_q;
        sel_idx  = idx_q + CW'(1);

        if (in_fire) begin
            state_d  = ST_BUSY;
            word_d   = bus.i_data;
            cnt_d    = in_cnt;
            last_d   = bus.i_last;
            idx_d    = '0;
            sel_word = bus.i_data;
            sel_idx  = '0;
            olast_d  = bus.i_last & (in_cnt == '0);
        end else if (out_fire) begin
            if (last_byte) begin
                state_d = ST_IDLE;
            end else begin
                idx_d   = sel_idx;
                olast_d = last_q & (sel_idx == cnt_q);
            end
        end

`ifdef STREAM_UNPACKER_MSB_FIRST_EN
        sel_pos = CW'(NB - 1) - sel_idx;
`else
        sel_pos = sel_idx;
`endif

        // One shared byte mux serves both a fresh word and the next held byte.
        if (in_fire | (out_fire & ~last_byte)) begin
            data_d = sel_word[BYTE_W*sel_pos +: BYTE_W];
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= ST_IDLE;
            word_q  <= '0;
            cnt_q   <= '0;
            idx_q   <= '0;
            last_q  <= 1'b0;
            data_q  <= '0;
            olast_q <= 1'b0;
        end else begin
            state_q <= state_d;
            word_q  <= word_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            last_q  <= last_d;
            data_q  <= data_d;
            olast_q <= olast_d;
        end
    end

    assign bus.i_rdy  = rdy;
    assign bus.o_en   = (state_q == ST_BUSY);
    assign bus.o_data = data_q;
    assign bus.o_last = olast_q;

endmodule
`default_nettype wire

// File: doc/stream_unpacker.md
Name: stream_unpacker

Overview:
Reader-side stream width converter that drains a word-wide FIFO output and emits a byte stream.
- Accepts NB-byte words, each with a valid-byte count and an end-of-packet flag.
- Emits the valid bytes one per handshake, marking the final byte of a packet.
- Sits between a wide sync FIFO output (o_en/o_rdy style) and byte-oriented consumers such as an output port or a CRC unit.

Parameters:
NB, 4, bytes per input word (2..16)
CW, $clog2(NB) (min 1), width of the byte-count field; derived, must not be overridden

Ports:
clk      input   1       clock, all logic on posedge
rstn     input   1       asynchronous active-low reset
i_rdy    output  1       block can accept a word this cycle
i_en     input   1       input word valid; transfer when i_en & i_rdy
i_data   input   8*NB    input word
i_cnt    input   CW      number of valid bytes minus 1 (0 = 1 byte, NB-1 = full word)
i_last   input   1       word ends a packet
o_rdy    input   1       downstream accepts byte; transfer when o_en & o_rdy
o_en     output  1       output byte valid (registered)
o_data   output  8       output byte (registered)
o_last   output  1       final byte of a packet (registered; meaningful only while o_en=1)

Behaviour:
- Reset state:
  - o_en=0, o_data=0, o_last=0.
  - Holding register cleared, byte index idx=0, state IDLE.
  - i_rdy=1 after reset.
- Reset mid-operation discards the held word and any pending byte. There is no partial output after rstn rises.
- States:
  - IDLE: no word held.
  - BUSY: word held, o_en=1.
- i_rdy (combinational) = (state==IDLE) | (o_en & o_rdy & idx==cnt_q). Back-to-back words therefore sustain one byte per cycle with no bubble.
- i_rdy depends combinationally on o_rdy. Upstream must not make i_en depend combinationally on i_rdy.
- Input transfer at edge T:
  - Latch data, cnt, last into word_q, cnt_q, last_q; set idx=0.
  - At T+1: o_en=1, o_data=byte 0 of the word, o_last = last_q & (cnt_q==0). Latency is 1 cycle.
- Output transfer (o_en & o_rdy) with idx<cnt_q:
  - idx increments.
  - Next cycle o_data=byte idx+1, o_last = last_q & (idx+1==cnt_q).
- Output transfer with idx==cnt_q:
  - If a new word is accepted the same edge, proceed as an input transfer (stay BUSY).
  - Otherwise go to IDLE with o_en=0. o_data and o_last hold their values and are don't-care.
- Stall: while o_en=1 & o_rdy=0, o_data, o_last and idx are stable (valid-hold rule). o_en never drops without a handshake.
- Byte order is little-endian by default: byte k = i_data[8k+7:8k].
- Bytes above cnt_q are never emitted.
- i_cnt is unsigned and ranges 0..NB-1. For NB not a power of two, values ≥NB are illegal; the design clamps them to NB-1.
- i_en while i_rdy=0 is ignored. The word is not captured and upstream must hold it.

Optional Feature:
Macro: STREAM_UNPACKER_MSB_FIRST_EN
- Defined: byte k = i_data[8(NB-1-k)+7 : 8(NB-1-k)]. The first emitted byte is the most significant, and valid bytes are the top cnt+1 bytes.
- Undefined: little-endian order as above.
- Handshake, latency and o_last timing are identical in both builds.

Decomposition:
- Shared package stream_pkg holds:
  - localparam BYTE_W=8.
  - The state encoding (ST_IDLE=1'b0, ST_BUSY=1'b1).
  - A function cnt_clamp(cnt, NB) used by all width converters.
- No sub-module. The byte select is a single indexed part-select.

Test Plan:
- Reset, then one word i_data=32'h44332211, i_cnt=3, i_last=1, o_rdy=1 -> o_data 11,22,33,44 on 4 consecutive cycles; o_last=1 only with 44; i_rdy=1 on the 4th output cycle.
- Back-to-back words 32'hDDCCBBAA (cnt=3, last=0) then 32'h00000099 (cnt=0, last=1), i_en held high -> 5 contiguous output bytes AA,BB,CC,DD,99 with no idle cycle; o_last only on 99.
- Output stall: o_rdy toggled 1,0,0,1,... during word 32'h04030201 cnt=3 -> o_data holds 02 through the stall cycles; no byte lost or duplicated; i_rdy=0 until byte 04 is accepted.
- Partial word i_data=32'hFFFFAB12, i_cnt=1, i_last=1 -> exactly 2 bytes, 12 then AB (o_last=1); FF never appears.
- Assert rstn=0 after byte 22 of word 32'h44332211 -> o_en=0 immediately (async); after release no 33/44 emitted and i_rdy=1.
- With STREAM_UNPACKER_MSB_FIRST_EN defined, word 32'h11223344 cnt=3 -> 11,22,33,44; cnt=1 -> 11,22 only.
